can_tx_scheduler: RTL and testbench
===================================

CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 SHALL provide parameter NUM_MB, default 4, number of transmit mailboxes (2..8).
REQ-002 SHALL provide parameter RETRY_MAX, default 8, consecutive failures allowed before abort (used only with CAN_RETRY_LIMIT_EN).
REQ-003 SHALL provide port sys_clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL provide port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL provide port mb_req  in  NUM_MB  per-mailbox one-cycle transmit request pulse.
REQ-006 SHALL provide port mb_id  in  11*NUM_MB  per-mailbox standard identifier; mailbox k at bits [11k+:11].
REQ-007 SHALL provide port mb_dlc  in  4*NUM_MB  per-mailbox data length code (0..8); values 9..15 are treated as 8.
REQ-008 SHALL provide port mb_data  in  64*NUM_MB  per-mailbox payload; byte 0 in the LSBs.
REQ-009 SHALL provide port bus_idle  in  1  frame engine reports the bus free (EOF plus intermission seen).
REQ-010 SHALL provide port tx_done  in  1  engine pulse: frame sent and acknowledged.
REQ-011 SHALL provide port tx_lost  in  1  engine pulse: arbitration lost.
REQ-012 SHALL provide port tx_err  in  1  engine pulse: bit, CRC or ACK error.
REQ-013 SHALL provide port tx_start  out  1  one-cycle launch pulse to the frame engine.
REQ-014 SHALL provide ports tx_id/tx_dlc/tx_data  out  11/4/64  latched frame; stable from SELECT until return to IDLE.
REQ-015 SHALL provide port mb_pending  out  NUM_MB  mailbox awaiting transmission.
REQ-016 SHALL provide port mb_done  out  NUM_MB  one-cycle pulse on successful send.
REQ-017 SHALL provide port mb_abort  out  NUM_MB  one-cycle pulse on retry-limit abort.
REQ-018 SHALL provide port active_mb  out  3  index of the latched mailbox; valid when state is not IDLE.

Function
REQ-019 SHALL set pending[k] on the edge that samples mb_req[k]=1; a request to an already-pending mailbox is ignored.
REQ-020 SHALL implement states IDLE, SELECT, LAUNCH, ACTIVE and RETIRE.
REQ-021 SHALL move IDLE->SELECT when any pending bit is set.
REQ-022 In SELECT, SHALL latch the pending mailbox with the numerically lowest mb_id onto tx_*/active_mb; an ID tie goes to the lowest index; next state is LAUNCH.
REQ-023 In LAUNCH, SHALL wait for bus_idle=1, then assert tx_start for exactly one cycle and enter ACTIVE.
REQ-024 With bus_idle held high, tx_start SHALL assert in the third cycle after the edge that samples mb_req (pending, SELECT, LAUNCH).
REQ-025 In ACTIVE on tx_done, SHALL go to RETIRE, clear pending[active_mb], pulse mb_done[active_mb] and clear that mailbox's failure count.
REQ-026 In ACTIVE on tx_lost or tx_err, SHALL increment the mailbox failure count (saturating, 4 bits), keep pending set and return to IDLE, so the mailbox re-arbitrates against newly pending ones.
REQ-027 If tx_done arrives in the same cycle as tx_lost or tx_err, tx_done SHALL win.
REQ-028 An mb_req to the mailbox being retired in the same cycle as its done SHALL leave pending set (new request wins).
REQ-029 RETIRE SHALL last one cycle and then return to IDLE.
REQ-030 SHALL ignore tx_done, tx_lost and tx_err outside ACTIVE.

Reset
REQ-031 While reset_n=0, SHALL force state IDLE, clear pending bits and failure counts, tx_start=0, mb_done=0, mb_abort=0, tx_id=0, tx_dlc=0, tx_data=0 and active_mb=0, regardless of the clock.
REQ-032 If reset asserts mid-frame, SHALL not emit a completion or abort pulse for the interrupted mailbox.

Configuration
REQ-033 With CAN_RETRY_LIMIT_EN defined, a failure that brings the count to RETRY_MAX SHALL clear pending, pulse mb_abort[active_mb], reset the count and return to IDLE.
REQ-034 Without CAN_RETRY_LIMIT_EN, SHALL retry indefinitely; mb_abort is tied to 0 and no failure counters are instantiated.

Verification
REQ-035 Scenario: mb_req=4'b0001, id0=0x123, bus_idle=1 -> tx_start 3 cycles later with tx_id=0x123; tx_done -> mb_done[0] pulse, pending=0.
REQ-036 Scenario: simultaneous req on mb1 (0x200) and mb3 (0x080) -> mb3 sent first, then mb1.
REQ-037 Scenario: ID tie 0x100 on mb0 and mb2 -> mb0 first.
REQ-038 Scenario: mb0 0x300 gets tx_lost while mb2 0x010 becomes pending -> mb2 launched next, then mb0 retried.
REQ-039 Scenario: with CAN_RETRY_LIMIT_EN and RETRY_MAX=3, three tx_err on mb1 -> mb_abort[1] pulse, pending[1]=0; without the macro -> fourth tx_start occurs.
REQ-040 Scenario: reset_n low during ACTIVE -> all outputs at reset values immediately, and no mb_done or mb_abort pulse.

Source files
------------

// File: rtl/can_tx_scheduler_if.sv
// Mailbox-side and frame-engine-side signals of the CAN transmit scheduler.
interface can_tx_scheduler_if #(
    parameter int unsigned NUM_MB = 4
);
    logic [NUM_MB-1:0]    mb_req;
    logic [11*NUM_MB-1:0] mb_id;
    logic [4*NUM_MB-1:0]  mb_dlc;
    logic [64*NUM_MB-1:0] mb_data;
    logic                 bus_idle;
    logic                 tx_done;
    logic                 tx_lost;
    logic                 tx_err;
    logic                 tx_start;
    logic [10:0]          tx_id;
    logic [3:0]           tx_dlc;
    logic [63:0]          tx_data;
    logic [NUM_MB-1:0]    mb_pending;
    logic [NUM_MB-1:0]    mb_done;
    logic [NUM_MB-1:0]    mb_abort;
    logic [2:0]           active_mb;

    modport master (
        output mb_req, mb_id, mb_dlc, mb_data, bus_idle, tx_done, tx_lost, tx_err,
        input  tx_start, tx_id, tx_dlc, tx_data, mb_pending, mb_done, mb_abort, active_mb
    );

    modport slave (
        input  mb_req, mb_id, mb_dlc, mb_data, bus_idle, tx_done, tx_lost, tx_err,
        output tx_start, tx_id, tx_dlc, tx_data, mb_pending, mb_done, mb_abort, active_mb
    );
endinterface

// File: rtl/can_tx_scheduler.sv
// CAN transmit mailbox scheduler: lowest-ID arbitration, frame launch and retry control.
// Define CAN_RETRY_LIMIT_EN to add per-mailbox failure counters that abort at RETRY_MAX.
module can_tx_scheduler #(
    parameter int unsigned NUM_MB    = 4,
    parameter int unsigned RETRY_MAX = 8
) (
    input logic               sys_clk,
    input logic               reset_n,
    can_tx_scheduler_if.slave bus
);
    localparam int unsigned ID_W   = 11;
    localparam int unsigned DLC_W  = 4;
    localparam int unsigned DATA_W = 64;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_RETIRE = 3'd4;

    if (NUM_MB < 2 || NUM_MB > 8 || RETRY_MAX < 1 || RETRY_MAX > 15) begin : g_param_check
        $error("can_tx_scheduler: NUM_MB must be 2..8 and RETRY_MAX 1..15");
    end

    logic [2:0]        state, state_nxt;
    logic [NUM_MB-1:0] pending, pending_nxt;
    logic [NUM_MB-1:0] clr_mask, abort_clr;
    logic              tx_start_q, tx_start_nxt;
    logic [ID_W-1:0]   tx_id_q, tx_id_nxt;
    logic [DLC_W-1:0]  tx_dlc_q, tx_dlc_nxt;
    logic [DATA_W-1:0] tx_data_q, tx_data_nxt;
    logic [2:0]        active_q, active_nxt;
    logic [NUM_MB-1:0] done_q, done_nxt;
    logic [NUM_MB-1:0] act_oh;

    logic              win_found;
    logic [2:0]        win_idx;
    logic [ID_W-1:0]   win_id;
    logic [DLC_W-1:0]  win_dlc;
    logic [DATA_W-1:0] win_data;

    // Lowest ID among pending mailboxes; strict compare keeps the lowest index on a tie.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_id    = '0;
        win_dlc   = '0;
        win_data  = '0;
        for (int k = 0; k < NUM_MB; k++) begin
            if (pending[k] && (!win_found || (bus.mb_id[ID_W*k +: ID_W] < win_id))) begin
                win_found = 1'b1;
                win_idx   = 3'(k);
                win_id    = bus.mb_id[ID_W*k +: ID_W];
                win_dlc   = bus.mb_dlc[DLC_W*k +: DLC_W];
                win_data  = bus.mb_data[DATA_W*k +: DATA_W];
            end
        end
    end

    always_comb begin
        act_oh = '0;
        for (int k = 0; k < NUM_MB; k++) act_oh[k] = (active_q == 3'(k));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt    = state;
        tx_start_nxt = 1'b0;
        tx_id_nxt    = tx_id_q;
        tx_dlc_nxt   = tx_dlc_q;
        tx_data_nxt  = tx_data_q;
        active_nxt   = active_q;
        done_nxt     = '0;
        clr_mask     = '0;
        case (state)
            S_IDLE: begin
                if (|pending) state_nxt = S_SELECT;
            end
            S_SELECT: begin
                tx_id_nxt    = win_id;
                tx_dlc_nxt   = (win_dlc > 4'd8) ? 4'd8 : win_dlc;
                tx_data_nxt  = win_data;
                active_nxt   = win_idx;
                tx_start_nxt = bus.bus_idle;
                state_nxt    = S_LAUNCH;
            end
            S_LAUNCH: begin
                // The pulse is already on the wire this cycle; hand over to the engine.
                if (tx_start_q) state_nxt = S_ACTIVE;
                else            tx_start_nxt = bus.bus_idle;
            end
            S_ACTIVE: begin
                if (bus.tx_done) begin
                    state_nxt = S_RETIRE;
                    done_nxt  = act_oh;
                    clr_mask  = act_oh;
                end else if (bus.tx_lost || bus.tx_err) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RETIRE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

`ifdef CAN_RETRY_LIMIT_EN
    logic [3:0]        fail_cnt     [NUM_MB];
    logic [3:0]        fail_cnt_nxt [NUM_MB];
    logic [NUM_MB-1:0] abort_q, abort_nxt;
    logic              fail_ev;

    // Saturating per-mailbox failure count; reaching RETRY_MAX drops the mailbox.
    always_comb begin
        fail_ev   = (state == S_ACTIVE) && !bus.tx_done && (bus.tx_lost || bus.tx_err);
        abort_nxt = '0;
        for (int k = 0; k < NUM_MB; k++) begin
            fail_cnt_nxt[k] = fail_cnt[k];
            if (act_oh[k]) begin
                if (done_nxt[k]) begin
                    fail_cnt_nxt[k] = '0;
                end else if (fail_ev) begin
                    if (({1'b0, fail_cnt[k]} + 5'd1) >= 5'(RETRY_MAX)) begin
                        abort_nxt[k]    = 1'b1;
                        fail_cnt_nxt[k] = '0;
                    end else if (fail_cnt[k] != 4'hF) begin
                        fail_cnt_nxt[k] = fail_cnt[k] + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            abort_q <= '0;
            for (int k = 0; k < NUM_MB; k++) fail_cnt[k] <= '0;
        end else begin
            abort_q <= abort_nxt;
            for (int k = 0; k < NUM_MB; k++) fail_cnt[k] <= fail_cnt_nxt[k];
        end
    end

    assign abort_clr    = abort_nxt;
    assign bus.mb_abort = abort_q;
`else
    assign abort_clr    = '0;
    assign bus.mb_abort = '0;
`endif

    // A request landing on the retire edge re-arms the mailbox.
    assign pending_nxt = (pending & ~(clr_mask | abort_clr)) | bus.mb_req;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            pending    <= '0;
            tx_start_q <= 1'b0;
            tx_id_q    <= '0;
            tx_dlc_q   <= '0;
            tx_data_q  <= '0;
            active_q   <= '0;
            done_q     <= '0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            tx_start_q <= tx_start_nxt;
            tx_id_q    <= tx_id_nxt;
            tx_dlc_q   <= tx_dlc_nxt;
            tx_data_q  <= tx_data_nxt;
            active_q   <= active_nxt;
            done_q     <= done_nxt;
        end
    end

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_id      = tx_id_q;
    assign bus.tx_dlc     = tx_dlc_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.active_mb  = active_q;
    assign bus.mb_pending = pending;
    assign bus.mb_done    = done_q;
endmodule

// File: tb/tb_can_tx_scheduler.sv
// Scoreboard bench for can_tx_scheduler: the bench plays the frame engine and predicts
// launch order, completions and aborts from the arbitration rules.
module tb_can_tx_scheduler;
    localparam int unsigned NUM   = 4;
    localparam int unsigned RETRY = 3;
    localparam int          TO    = 60;

    logic sys_clk = 1'b0;
    logic reset_n;
    always #5 sys_clk = ~sys_clk;

    can_tx_scheduler_if #(.NUM_MB(NUM)) sif ();
    can_tx_scheduler #(.NUM_MB(NUM), .RETRY_MAX(RETRY)) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (sif)
    );

    // kind: 0 launch, 1 done, 2 abort
    typedef struct {
        int          kind;
        int          mb;
        logic [10:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
    } ev_t;

    // outcome: 0 done, 1 lost, 2 err, 3 done+lost, 4 done+re-request
    typedef struct {
        int             outcome;
        logic [NUM-1:0] inj;
    } frc_t;

    ev_t  exp_q[$];
    frc_t frc_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0]    m_id   [NUM];
    logic [3:0]     m_dlc  [NUM];
    logic [63:0]    m_data [NUM];
    int             m_fail [NUM];
    logic [NUM-1:0] m_pend;
    int             cur;
    bit             rnd_mode;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_payload();
        for (int k = 0; k < NUM; k++) begin
            sif.mb_id[11*k +: 11]  = m_id[k];
            sif.mb_dlc[4*k +: 4]   = m_dlc[k];
            sif.mb_data[64*k +: 64] = m_data[k];
        end
    endtask

    task automatic issue(input logic [NUM-1:0] mask);
        for (int k = 0; k < NUM; k++) begin
            if (mask[k] && !m_pend[k] && rnd_mode) begin
                m_id[k]   = ($urandom_range(0, 3) == 0) ? m_id[$urandom_range(0, NUM-1)] : 11'($urandom);
                m_dlc[k]  = 4'($urandom);
                m_data[k] = {$urandom, $urandom};
            end
        end
        drive_payload();
        sif.mb_req = mask;
        m_pend     = m_pend | mask;
        @(posedge sys_clk); #1;
        sif.mb_req = '0;
    endtask

    // Next frame: pending mailbox with the lowest identifier, lowest index on a tie.
    task automatic push_launch();
        int best;
        best = -1;
        for (int k = 0; k < NUM; k++)
            if (m_pend[k] && (best < 0 || m_id[k] < m_id[best])) best = k;
        if (best >= 0) begin
            cur = best;
            exp_q.push_back('{kind: 0, mb: best, id: m_id[best],
                              dlc: (m_dlc[best] > 4'd8) ? 4'd8 : m_dlc[best], data: m_data[best]});
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(posedge sys_clk); #1;
            n++;
        end while (!sif.tx_start && n < TO);
    endtask

    task automatic serve_all(input bit lat_in);
        int   n, guard, r, d;
        bit   lat;
        frc_t f;
        lat   = lat_in;
        guard = 0;
        while (m_pend != '0 && guard < 200) begin
            guard++;
            wait_start(n);
            if (!sif.tx_start) begin
                chk("launch_timeout", 64'(sif.tx_start), 1);
                return;
            end
            if (lat) begin
                chk("launch_latency", 64'(n + 1), 3);
                lat = 0;
            end
            @(posedge sys_clk); #1;
            chk("start_width", 64'(sif.tx_start), 0);
            if (frc_q.size() > 0) begin
                f = frc_q.pop_front();
            end else begin
                r = $urandom_range(0, 9);
                f.outcome = (r < 5) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 4;
                f.inj = ($urandom_range(0, 2) == 0) ? NUM'($urandom) : NUM'(0);
            end
            f.inj = f.inj & ~m_pend;
            if (f.inj != '0) issue(f.inj);
            d = $urandom_range(0, 2);
            repeat (d) begin @(posedge sys_clk); #1; end
            case (f.outcome)
                0:       sif.tx_done = 1'b1;
                1:       sif.tx_lost = 1'b1;
                2:       sif.tx_err  = 1'b1;
                3:       begin sif.tx_done = 1'b1; sif.tx_lost = 1'b1; end
                default: begin sif.tx_done = 1'b1; sif.mb_req[cur] = 1'b1; end
            endcase
            if (f.outcome == 1 || f.outcome == 2) begin
                m_fail[cur]++;
`ifdef CAN_RETRY_LIMIT_EN
                if (m_fail[cur] == RETRY) begin
                    m_fail[cur]  = 0;
                    m_pend[cur]  = 1'b0;
                    exp_q.push_back('{kind: 2, mb: cur, id: '0, dlc: '0, data: '0});
                end
`endif
            end else begin
                m_fail[cur] = 0;
                if (f.outcome != 4) m_pend[cur] = 1'b0;
                exp_q.push_back('{kind: 1, mb: cur, id: '0, dlc: '0, data: '0});
            end
            @(posedge sys_clk); #1;
            sif.tx_done = 1'b0;
            sif.tx_lost = 1'b0;
            sif.tx_err  = 1'b0;
            sif.mb_req  = '0;
            chk("pending_after_resp", 64'(sif.mb_pending), 64'(m_pend));
            push_launch();
        end
    endtask

    task automatic round(input logic [NUM-1:0] mask, input bit hold);
        if (hold) sif.bus_idle = 1'b0;
        issue(mask);
        push_launch();
        if (hold) begin
            // Engine strobes outside ACTIVE must be ignored.
            sif.tx_done = 1'b1;
            sif.tx_err  = 1'b1;
            repeat (5) begin @(posedge sys_clk); #1; end
            chk("start_while_busy", 64'(sif.tx_start), 0);
            sif.tx_done  = 1'b0;
            sif.tx_err   = 1'b0;
            sif.bus_idle = 1'b1;
        end
        serve_all(!hold);
        repeat (2) begin @(posedge sys_clk); #1; end
        chk("pending_idle", 64'(sif.mb_pending), 64'(m_pend));
    endtask

    // Monitor: every launch / done / abort the DUT presents is matched against the queue.
    initial begin
        ev_t            e;
        logic [NUM-1:0] oh;
        forever begin
            @(negedge sys_clk);
            if (reset_n && (sif.tx_start || (|sif.mb_done) || (|sif.mb_abort))) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'({sif.mb_abort, sif.mb_done, sif.tx_start}), 0);
                end else begin
                    e  = exp_q.pop_front();
                    oh = NUM'(1) << e.mb;
                    chk("ev_start", 64'(sif.tx_start), 64'(e.kind == 0));
                    chk("ev_done", 64'(sif.mb_done), (e.kind == 1) ? 64'(oh) : 64'(0));
                    chk("ev_abort", 64'(sif.mb_abort), (e.kind == 2) ? 64'(oh) : 64'(0));
                    if (e.kind == 0) begin
                        chk("launch_id", 64'(sif.tx_id), 64'(e.id));
                        chk("launch_dlc", 64'(sif.tx_dlc), 64'(e.dlc));
                        chk("launch_data", sif.tx_data, e.data);
                        chk("launch_mb", 64'(sif.active_mb), 64'(e.mb));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int n;
        reset_n      = 1'b1;
        sif.mb_req   = '0;
        sif.mb_id    = '0;
        sif.mb_dlc   = '0;
        sif.mb_data  = '0;
        sif.bus_idle = 1'b1;
        sif.tx_done  = 1'b0;
        sif.tx_lost  = 1'b0;
        sif.tx_err   = 1'b0;
        m_pend       = '0;
        rnd_mode     = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            m_id[k] = '0; m_dlc[k] = '0; m_data[k] = '0; m_fail[k] = 0;
        end
        #3 reset_n = 1'b0;
        #1;
        chk("rst_tx_start", 64'(sif.tx_start), 0);
        chk("rst_tx_id", 64'(sif.tx_id), 0);
        chk("rst_pending", 64'(sif.mb_pending), 0);
        chk("rst_done_abort", 64'({sif.mb_done, sif.mb_abort}), 0);
        chk("rst_active_mb", 64'(sif.active_mb), 0);
        repeat (3) @(posedge sys_clk);
        #1 reset_n = 1'b1;
        @(posedge sys_clk); #1;

        // Single request, id 0x123
        m_id[0] = 11'h123; m_dlc[0] = 4'd8; m_data[0] = 64'h0706050403020100;
        frc_q.push_back('{outcome: 0, inj: NUM'(0)});
        round(4'b0001, 1'b0);

        // Simultaneous requests: lower id on mb3 first
        m_id[1] = 11'h200; m_dlc[1] = 4'd2;  m_data[1] = 64'h1111;
        m_id[3] = 11'h080; m_dlc[3] = 4'd12; m_data[3] = 64'h3333_4444_5555_6666;
        frc_q.push_back('{outcome: 0, inj: NUM'(0)});
        frc_q.push_back('{outcome: 0, inj: NUM'(0)});
        round(4'b1010, 1'b0);

        // ID tie: lowest index wins
        m_id[0] = 11'h100; m_id[2] = 11'h100; m_data[2] = 64'h2222;
        frc_q.push_back('{outcome: 0, inj: NUM'(0)});
        frc_q.push_back('{outcome: 0, inj: NUM'(0)});
        round(4'b0101, 1'b0);

        // Lost arbitration while a lower id arrives
        m_id[0] = 11'h300; m_id[2] = 11'h010;
        frc_q.push_back('{outcome: 1, inj: NUM'(4'b0100)});
        frc_q.push_back('{outcome: 0, inj: NUM'(0)});
        frc_q.push_back('{outcome: 0, inj: NUM'(0)});
        round(4'b0001, 1'b0);

        // Repeated errors on mb1
        m_id[1] = 11'h055;
        repeat (3) frc_q.push_back('{outcome: 2, inj: NUM'(0)});
`ifndef CAN_RETRY_LIMIT_EN
        frc_q.push_back('{outcome: 0, inj: NUM'(0)});
`endif
        round(4'b0010, 1'b0);

        rnd_mode = 1'b1;
        for (int r = 0; r < 40; r++)
            round(NUM'($urandom_range(1, (1 << NUM) - 1)), (r % 5) == 4);

        // Reset during ACTIVE: outputs clear at once, no completion pulse follows
        issue(4'b0010);
        push_launch();
        wait_start(n);
        chk("rst_launch_seen", 64'(sif.tx_start), 1);
        @(posedge sys_clk); #1;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_tx_start", 64'(sif.tx_start), 0);
        chk("midrst_tx_id", 64'(sif.tx_id), 0);
        chk("midrst_tx_dlc", 64'(sif.tx_dlc), 0);
        chk("midrst_tx_data", sif.tx_data, 0);
        chk("midrst_active_mb", 64'(sif.active_mb), 0);
        chk("midrst_pending", 64'(sif.mb_pending), 0);
        chk("midrst_done_abort", 64'({sif.mb_done, sif.mb_abort}), 0);
        exp_q.delete();
        m_pend = '0;
        for (int k = 0; k < NUM; k++) m_fail[k] = 0;
        repeat (3) @(posedge sys_clk);
        #1 reset_n = 1'b1;
        sif.tx_done = 1'b1;
        @(posedge sys_clk); #1;
        sif.tx_done = 1'b0;
        repeat (4) begin @(posedge sys_clk); #1; end
        chk("postrst_pending", 64'(sif.mb_pending), 64'(m_pend));

        round(4'b0001, 1'b0);

        repeat (5) begin @(posedge sys_clk); #1; end
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
